ccm_output_writeback: RTL and testbench
=======================================

Name: ccm_output_writeback

Overview:
- Downstream stage of the CCM cluster controller.
- Accepts each 512-bit MAC result beat (2 output rows x 16 pixels x 16 bit) over the PRE_TAKE valid/ready handshake.
- Serialises the beat into 16-bit writes to the output feature-map memory through a req/grant port, dropping lanes beyond the valid output width/height.
- Tracks kernel/row/column position so that each output map lands contiguously at out_base_addr.

Parameters:
- DATA_W, 16, pixel/result width.
- LANES, 16, pixels per row per beat.
- ROWS, 2, output rows per beat.
- ADDR_W, 20, output memory address width.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_start  in  1  single-cycle pulse; sampled only when idle.
- busy  out  1  high from the cycle after op_start until the last write is granted.
- done  out  1  one-cycle pulse after the final grant.
- MAC_OUT  in  ROWS*LANES*DATA_W  result beat.
- PRE_TAKE_VLD  in  1  beat valid.
- PRE_TAKE_RDY  out  1  beat accepted when VLD&RDY.
- outMem_WR_REQ  out  1  write request.
- outMem_WR_GRANT  in  1  write accepted this cycle.
- outMem_WR_Addr  out  ADDR_W  write address.
- outMem_WR_Data  out  DATA_W  write data.
- out_base_addr  in  ADDR_W  base address of kernel 0 output map; latched at op_start.
- CFG_WIDTH  in  9  input map width; latched at op_start.
- CFG_HEIGHT  in  9  input map height; latched at op_start.
- CFG_NUM_KERNEL  in  10  number of kernels; latched at op_start.
- CFG_KERN_SIZE  in  3  kernel size; latched at op_start.

Behaviour:
- Reset state: busy=0, done=0, PRE_TAKE_RDY=0, outMem_WR_REQ=0, Addr=0, Data=0, FSM in IDLE, all counters at 0.
- Derived sizes, registered at op_start:
  - OW = W-K+1 and OH = H-K+1, each 9 bit.
  - plane = OW*OH, computed once with a single multiply and registered.
- Beat lane map:
  - bits [16*i+15 : 16*i] = row r0, pixel i, for i=0..15.
  - bits [256+16*i+15 : 256+16*i] = row r0+1, pixel i.
- Traversal order (fixed, matches upstream): kernel outer, row pair (r0 += 2) middle, column block (c0 += 16) inner.
- FSM:
  - IDLE: op_start -> CAPT, with all counters cleared and kbase=out_base_addr.
  - CAPT: PRE_TAKE_RDY=1. On VLD&RDY, register the beat, lane=0 -> WRITE. PRE_TAKE_RDY is low in every other state, so only one beat is buffered.
  - WRITE: for the current lane (row = lane[4], col = lane[3:0]):
    - Valid when c0+col < OW and r0+row < OH.
    - If valid: assert REQ with Addr = kbase + (r0+row)*OW + c0 + col and Data = lane value. Hold all three stable until GRANT is sampled high, then advance the lane.
    - If invalid: skip the lane in one cycle with no REQ.
    - After lane 31 -> ADV.
  - ADV: advance c0. On wrap, advance r0 and the row base. On row wrap, advance the kernel and kbase += plane.
    - If all kernels are done -> DONE, else -> CAPT.
  - DONE: pulse done for one cycle, busy=0 -> IDLE.
- Row address is built incrementally: rowbase += OW per row. No per-lane multiply.
- Write throughput: at most one write per cycle. REQ may stay high back-to-back across consecutive granted lanes.
- Boundary conditions:
  - OW not a multiple of 16: the last column block writes only OW mod 16 lanes.
  - Odd OH: the row r0+1 lanes of the last pair are all skipped.
  - op_start while busy is ignored.
  - A VLD that is high outside CAPT is not consumed.
  - An asynchronous rst mid-operation returns to IDLE immediately and drops REQ. Any partial output is abandoned; there is no resume.
  - GRANT without REQ is ignored.

Optional Feature:
- Macro CCM_WB_RELU_EN.
- When defined: Data = 0 when the lane value is negative (signed, bit 15 set), otherwise the lane value. The ReLU is applied in the WRITE stage and adds no latency.
- When undefined: data is passed unchanged.

Decomposition:
- Shared package ccm_pkg holds:
  - DATA_W, LANES, ROWS, ADDR_W.
  - The FSM state enum (IDLE, CAPT, WRITE, ADV, DONE).
  - The lane-slice helper function.
- One sub-module, ccm_wb_addr_gen: position counters, valid mask and address generation. The top module holds the FSM, the beat buffer and the memory handshake.

Test Plan:
- W=H=32, K=5, 6 kernels, base 0, GRANT tied 1, VLD tied 1:
  - exactly 168 beats accepted and 4704 writes;
  - last address 4703; one done pulse; busy low afterwards.
- Same config, beat lane value = lane index:
  - second column block writes only lanes 0-11 (cols 16-27);
  - no write has col >= 28.
- W=H=21, K=4 (OH=18), then K=3 (OH=19):
  - with OH=19 the last row pair writes row 18 only;
  - address never reaches the plane size per kernel.
- GRANT withheld for 5 cycles mid-beat:
  - REQ, Addr and Data stay stable throughout;
  - no lane lost or duplicated;
  - PRE_TAKE_RDY stays 0.
- rst asserted during WRITE of beat 3:
  - all outputs return to reset values the same cycle;
  - a new op_start restarts at base address 0.
- With CCM_WB_RELU_EN, lane value 16'h8001 -> Data 0; 16'h0303 -> 16'h0303. Without the macro, 16'h8001 is passed unchanged.

Source files
------------

// File: rtl/ccm_pkg.sv
// Shared definitions for the CCM output writeback stage: beat geometry,
// the writeback FSM state type and the lane-slice helper.
package ccm_pkg;

  localparam int DATA_W = 16;
  localparam int LANES  = 16;
  localparam int ROWS   = 2;
  localparam int ADDR_W = 20;
  localparam int BEAT_W = ROWS * LANES * DATA_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAPT  = 3'd1,
    WRITE = 3'd2,
    ADV   = 3'd3,
    DONE  = 3'd4
  } wb_state_e;

  // Lane n of a beat: lanes 0..15 are row r0, lanes 16..31 are row r0+1.
  function automatic logic [DATA_W-1:0] lane_slice(input logic [BEAT_W-1:0] beat,
                                                   input logic [4:0]        lane);
    return beat[int'(lane)*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/ccm_wb_addr_gen.sv
// Position tracking for the output writeback: kernel / row-pair / column-block
// counters, per-lane valid mask and output address. Row addresses are built
// incrementally (rowbase advances by 2*OW per row pair); the only multiply is
// the plane size, evaluated once when the operation starts.
module ccm_wb_addr_gen
  import ccm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [8:0]        i_cfg_width,
  input  logic [8:0]        i_cfg_height,
  input  logic [9:0]        i_cfg_num_kernel,
  input  logic [2:0]        i_cfg_kern_size,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [4:0]        i_lane,
  input  logic              i_adv,
  output logic              o_lane_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [8:0]        r_ow;
  logic [8:0]        r_oh;
  logic [ADDR_W-1:0] r_plane;
  logic [9:0]        r_nk;
  logic [9:0]        r_c0;
  logic [9:0]        r_r0;
  logic [9:0]        r_kern;
  logic [ADDR_W-1:0] r_kbase;
  logic [ADDR_W-1:0] r_rowbase;

  logic [8:0]        w_ow;
  logic [8:0]        w_oh;
  logic [ADDR_W-1:0] w_plane;
  logic              w_row;
  logic [3:0]        w_col;
  logic [9:0]        w_cpos;
  logic [9:0]        w_rpos;
  logic [9:0]        w_c0_next;
  logic [9:0]        w_r0_next;
  logic [9:0]        w_kern_next;
  logic              w_col_wrap;
  logic              w_row_wrap;
  logic              w_kern_wrap;
  logic [ADDR_W-1:0] w_row_off;
  logic [ADDR_W-1:0] w_pair_step;
  logic [ADDR_W-1:0] w_next_kbase;

  // Output map size from the live configuration, captured at start.
  assign w_ow    = i_cfg_width  - 9'(i_cfg_kern_size) + 9'd1;
  assign w_oh    = i_cfg_height - 9'(i_cfg_kern_size) + 9'd1;
  assign w_plane = ADDR_W'(w_ow) * ADDR_W'(w_oh);

  // Current lane position within the output map.
  assign w_row  = i_lane[4];
  assign w_col  = i_lane[3:0];
  assign w_cpos = r_c0 + 10'(w_col);
  assign w_rpos = r_r0 + 10'(w_row);

  assign o_lane_valid = (w_cpos < 10'(r_ow)) && (w_rpos < 10'(r_oh));

  assign w_row_off = w_row ? ADDR_W'(r_ow) : '0;
  assign o_addr    = r_rowbase + w_row_off + ADDR_W'(w_cpos);

  // Wrap detection for the traversal: column block inner, row pair, kernel outer.
  assign w_c0_next    = r_c0 + 10'd16;
  assign w_r0_next    = r_r0 + 10'd2;
  assign w_kern_next  = r_kern + 10'd1;
  assign w_col_wrap   = w_c0_next >= 10'(r_ow);
  assign w_row_wrap   = w_r0_next >= 10'(r_oh);
  assign w_kern_wrap  = w_kern_next >= r_nk;
  assign w_pair_step  = ADDR_W'({r_ow, 1'b0});
  assign w_next_kbase = r_kbase + r_plane;

  assign o_last = w_col_wrap && w_row_wrap && w_kern_wrap;

  // Latch geometry at start, then step the position once per beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ow      <= '0;
      r_oh      <= '0;
      r_plane   <= '0;
      r_nk      <= '0;
      r_c0      <= '0;
      r_r0      <= '0;
      r_kern    <= '0;
      r_kbase   <= '0;
      r_rowbase <= '0;
    end else if (i_start) begin
      r_ow      <= w_ow;
      r_oh      <= w_oh;
      r_plane   <= w_plane;
      r_nk      <= i_cfg_num_kernel;
      r_c0      <= '0;
      r_r0      <= '0;
      r_kern    <= '0;
      r_kbase   <= i_base_addr;
      r_rowbase <= i_base_addr;
    end else if (i_adv) begin
      if (!w_col_wrap) begin
        r_c0 <= w_c0_next;
      end else begin
        r_c0 <= '0;
        if (!w_row_wrap) begin
          r_r0      <= w_r0_next;
          r_rowbase <= r_rowbase + w_pair_step;
        end else begin
          r_r0      <= '0;
          r_kern    <= w_kern_next;
          r_kbase   <= w_next_kbase;
          r_rowbase <= w_next_kbase;
        end
      end
    end
  end

endmodule

// File: rtl/ccm_output_writeback.sv
// CCM output writeback: buffers one 512-bit MAC beat at a time and serialises
// it into 16-bit writes to the output feature-map memory, skipping lanes that
// fall outside the output map.
// Optional build macro CCM_WB_RELU_EN: clamp negative lane values to zero on write.
//
// Handshakes: a beat moves when PRE_TAKE_VLD && PRE_TAKE_RDY at a rising edge;
// a write completes when outMem_WR_REQ && outMem_WR_GRANT at a rising edge.
// While REQ is high without GRANT, Addr and Data are held unchanged.
module ccm_output_writeback
  import ccm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              op_start,
  output logic              busy,
  output logic              done,
  input  logic [BEAT_W-1:0] MAC_OUT,
  input  logic              PRE_TAKE_VLD,
  output logic              PRE_TAKE_RDY,
  output logic              outMem_WR_REQ,
  input  logic              outMem_WR_GRANT,
  output logic [ADDR_W-1:0] outMem_WR_Addr,
  output logic [DATA_W-1:0] outMem_WR_Data,
  input  logic [ADDR_W-1:0] out_base_addr,
  input  logic [8:0]        CFG_WIDTH,
  input  logic [8:0]        CFG_HEIGHT,
  input  logic [9:0]        CFG_NUM_KERNEL,
  input  logic [2:0]        CFG_KERN_SIZE,
  output logic [2:0]        o_dbg_state
);

  wb_state_e         r_state;
  wb_state_e         w_state_next;
  logic [4:0]        r_lane;
  logic [BEAT_W-1:0] r_beat;

  logic              w_start;
  logic              w_capture;
  logic              w_lane_step;
  logic              w_adv;
  logic              w_lane_valid;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_lane_data;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_req;

  ccm_wb_addr_gen u_addr_gen (
    .clk              (clk),
    .rst              (rst),
    .i_start          (w_start),
    .i_cfg_width      (CFG_WIDTH),
    .i_cfg_height     (CFG_HEIGHT),
    .i_cfg_num_kernel (CFG_NUM_KERNEL),
    .i_cfg_kern_size  (CFG_KERN_SIZE),
    .i_base_addr      (out_base_addr),
    .i_lane           (r_lane),
    .i_adv            (w_adv),
    .o_lane_valid     (w_lane_valid),
    .o_addr           (w_addr),
    .o_last           (w_last)
  );

  assign w_lane_data = lane_slice(r_beat, r_lane);

`ifdef CCM_WB_RELU_EN
  assign w_wr_data = w_lane_data[DATA_W-1] ? '0 : w_lane_data;
`else
  assign w_wr_data = w_lane_data;
`endif

  // Outputs depend only on registered state, so reset clears them immediately.
  assign w_req          = (r_state == WRITE) && w_lane_valid;
  assign outMem_WR_REQ  = w_req;
  assign outMem_WR_Addr = w_req ? w_addr : '0;
  assign outMem_WR_Data = w_req ? w_wr_data : '0;
  assign PRE_TAKE_RDY   = (r_state == CAPT);
  assign busy           = (r_state != IDLE) && (r_state != DONE);
  assign done           = (r_state == DONE);
  assign o_dbg_state    = r_state;

  // Next-state and control strobes for the capture / write / advance loop.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_capture    = 1'b0;
    w_lane_step  = 1'b0;
    w_adv        = 1'b0;
    case (r_state)
      IDLE: begin
        if (op_start) begin
          w_start      = 1'b1;
          w_state_next = CAPT;
        end
      end
      CAPT: begin
        if (PRE_TAKE_VLD) begin
          w_capture    = 1'b1;
          w_state_next = WRITE;
        end
      end
      WRITE: begin
        // Out-of-map lanes retire in one cycle; valid lanes wait for GRANT.
        if (!w_lane_valid || outMem_WR_GRANT) begin
          w_lane_step = 1'b1;
          if (r_lane == 5'd31) begin
            w_state_next = ADV;
          end
        end
      end
      ADV: begin
        w_adv        = 1'b1;
        w_state_next = w_last ? DONE : CAPT;
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Beat buffer and lane pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane <= '0;
      r_beat <= '0;
    end else if (w_capture) begin
      r_lane <= '0;
      r_beat <= MAC_OUT;
    end else if (w_lane_step) begin
      r_lane <= r_lane + 5'd1;
    end
  end

endmodule

// File: tb/tb_ccm_output_writeback.sv
// Bench for ccm_output_writeback. A reference model enumerates the expected
// writes (address, data) directly from the output-map geometry with nested
// loops; the monitor pops them in order as writes are granted.
module tb_ccm_output_writeback;
  import ccm_pkg::*;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              op_start = 1'b0;
  logic              busy;
  logic              done;
  logic [BEAT_W-1:0] MAC_OUT = '0;
  logic              PRE_TAKE_VLD = 1'b0;
  logic              PRE_TAKE_RDY;
  logic              outMem_WR_REQ;
  logic              outMem_WR_GRANT = 1'b0;
  logic [ADDR_W-1:0] outMem_WR_Addr;
  logic [DATA_W-1:0] outMem_WR_Data;
  logic [ADDR_W-1:0] out_base_addr = '0;
  logic [8:0]        CFG_WIDTH = '0;
  logic [8:0]        CFG_HEIGHT = '0;
  logic [9:0]        CFG_NUM_KERNEL = '0;
  logic [2:0]        CFG_KERN_SIZE = '0;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  ccm_output_writeback dut (
    .clk             (clk),
    .rst             (rst),
    .op_start        (op_start),
    .busy            (busy),
    .done            (done),
    .MAC_OUT         (MAC_OUT),
    .PRE_TAKE_VLD    (PRE_TAKE_VLD),
    .PRE_TAKE_RDY    (PRE_TAKE_RDY),
    .outMem_WR_REQ   (outMem_WR_REQ),
    .outMem_WR_GRANT (outMem_WR_GRANT),
    .outMem_WR_Addr  (outMem_WR_Addr),
    .outMem_WR_Data  (outMem_WR_Data),
    .out_base_addr   (out_base_addr),
    .CFG_WIDTH       (CFG_WIDTH),
    .CFG_HEIGHT      (CFG_HEIGHT),
    .CFG_NUM_KERNEL  (CFG_NUM_KERNEL),
    .CFG_KERN_SIZE   (CFG_KERN_SIZE),
    .o_dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [BEAT_W-1:0]        beat_q[$];

  // Results of the most recent run.
  int res_beats, res_writes, res_dones, res_last_addr, res_first_addr;
  int res_max_col, res_max_row, res_cnt_8001, res_cnt_0303;
  int res_stalls;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_relu(input logic [DATA_W-1:0] v);
`ifdef CCM_WB_RELU_EN
    return v[DATA_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdy"},  PRE_TAKE_RDY, 0);
    chk({tag, "_req"},  outMem_WR_REQ, 0);
    chk({tag, "_addr"}, outMem_WR_Addr, 0);
    chk({tag, "_data"}, outMem_WR_Data, 0);
  endtask

  // ---------------- driver + monitor for one operation ----------------
  // dmode: 0 random, 1 lane index, 2 alternating 8001/0303.
  // hold_at: after this many granted writes, withhold GRANT 5 cycles (0 = never).
  // abort_beat: assert rst while writing this beat number (0 = never).
  task automatic run_op(input int w, input int h, input int k, input int nk,
                        input int base, input int gmode, input int vmode,
                        input int dmode, input int hold_at, input int abort_beat);
    int ow, oh, plane, budget, cyc, hold_left, rel;
    bit finished, prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_data;
    logic [ADDR_W+DATA_W-1:0] ent;
    ow = w - k + 1;
    oh = h - k + 1;
    plane = ow * oh;
    exp_q.delete();
    beat_q.delete();
    for (int kk = 0; kk < nk; kk++)
      for (int r0 = 0; r0 < oh; r0 += 2)
        for (int c0 = 0; c0 < ow; c0 += 16) begin
          logic [BEAT_W-1:0] b;
          b = '0;
          for (int ln = 0; ln < 32; ln++) begin
            logic [DATA_W-1:0] v;
            if (dmode == 0)      v = 16'($urandom);
            else if (dmode == 1) v = 16'(ln);
            else                 v = ln[0] ? 16'h0303 : 16'h8001;
            b[ln*DATA_W +: DATA_W] = v;
            if ((c0 + ln % 16 < ow) && (r0 + ln / 16 < oh))
              exp_q.push_back({20'(base + kk*plane + (r0 + ln/16)*ow + c0 + ln%16), ref_relu(v)});
          end
          beat_q.push_back(b);
        end

    res_beats = 0; res_writes = 0; res_dones = 0; res_last_addr = -1; res_first_addr = -1;
    res_max_col = 0; res_max_row = 0; res_cnt_8001 = 0; res_cnt_0303 = 0; res_stalls = 0;
    budget = beat_q.size() * 90 + 200;
    hold_left = 0;
    prev_stall = 0;
    prev_addr = '0;
    prev_data = '0;
    finished = 0;

    @(negedge clk);
    CFG_WIDTH = 9'(w); CFG_HEIGHT = 9'(h); CFG_KERN_SIZE = 3'(k);
    CFG_NUM_KERNEL = 10'(nk); out_base_addr = 20'(base);
    op_start = 1'b1;
    PRE_TAKE_VLD = 1'b1;
    MAC_OUT = beat_q[0];
    @(negedge clk);
    op_start = 1'b0;
    chk("busy_after_start", busy, 1);
    // Configuration is latched; scramble it to prove that.
    CFG_WIDTH = 9'($urandom); CFG_HEIGHT = 9'($urandom);
    CFG_KERN_SIZE = 3'($urandom); CFG_NUM_KERNEL = 10'($urandom);
    out_base_addr = 20'($urandom);

    cyc = 0;
    while (!finished && cyc < budget) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      // Drive inputs for the coming rising edge.
      op_start = (cyc == 50);
      if (beat_q.size() > 0) begin
        MAC_OUT = beat_q[0];
        PRE_TAKE_VLD = (vmode != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      end else begin
        MAC_OUT = {16{$urandom}};
        PRE_TAKE_VLD = 1'($urandom_range(0, 1));
      end
      if (hold_left > 0) begin
        outMem_WR_GRANT = 1'b0;
        hold_left--;
      end else begin
        outMem_WR_GRANT = (gmode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      #1;
      if (abort_beat > 0 && res_beats == abort_beat && outMem_WR_REQ) begin
        rst = 1'b1;
        #1;
        chk_idle_outputs("abort");
        return;
      end
      if (prev_stall) begin
        res_stalls++;
        chk("hold_req",  outMem_WR_REQ, 1);
        chk("hold_addr", outMem_WR_Addr, prev_addr);
        chk("hold_data", outMem_WR_Data, prev_data);
        chk("hold_rdy",  PRE_TAKE_RDY, 0);
      end
      if (done) begin
        res_dones++;
        finished = 1;
      end
      if (PRE_TAKE_RDY && PRE_TAKE_VLD) begin
        res_beats++;
        if (beat_q.size() > 0) void'(beat_q.pop_front());
      end
      if (outMem_WR_REQ && outMem_WR_GRANT) begin
        if (exp_q.size() == 0) begin
          chk("extra_write", 1, 0);
        end else begin
          ent = exp_q.pop_front();
          chk("wr_addr", outMem_WR_Addr, ent[ADDR_W+DATA_W-1:DATA_W]);
          chk("wr_data", outMem_WR_Data, ent[DATA_W-1:0]);
        end
        res_writes++;
        res_last_addr = int'(outMem_WR_Addr);
        if (res_first_addr < 0) res_first_addr = int'(outMem_WR_Addr);
        rel = int'(outMem_WR_Addr) - base;
        if (rel >= 0 && plane > 0) begin
          if (rel % ow > res_max_col) res_max_col = rel % ow;
          if ((rel % plane) / ow > res_max_row) res_max_row = (rel % plane) / ow;
        end
        if (outMem_WR_Data == 16'h8001) res_cnt_8001++;
        if (outMem_WR_Data == 16'h0303) res_cnt_0303++;
        if (hold_at > 0 && res_writes == hold_at) hold_left = 5;
      end
      prev_stall = outMem_WR_REQ && !outMem_WR_GRANT;
      prev_addr  = outMem_WR_Addr;
      prev_data  = outMem_WR_Data;
    end
    if (!finished) chk("timeout", 0, 1);
    PRE_TAKE_VLD = 1'b0;
    outMem_WR_GRANT = 1'b0;
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_pulse", done, 0);
    chk("beats", res_beats, ((oh + 1) / 2) * ((ow + 15) / 16) * nk);
    chk("writes", res_writes, ow * oh * nk);
    chk("dones", res_dones, 1);
    chk("exp_left", exp_q.size(), 0);
    chk("last_addr", res_last_addr, base + nk * plane - 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // 32x32, K=5, 6 kernels, everything flowing.
    run_op(32, 32, 5, 6, 0, 0, 0, 0, 0, 0);
    chk("t1_beats", res_beats, 168);
    chk("t1_writes", res_writes, 4704);
    chk("t1_last", res_last_addr, 4703);

    // Lane-index data: columns never exceed OW-1 = 27.
    run_op(32, 32, 5, 6, 0, 0, 0, 1, 0, 0);
    chk("t2_max_col", res_max_col, 27);

    // Odd and even output heights with random flow control and a base offset.
    run_op(21, 21, 4, 3, 1000, 1, 1, 0, 0, 0);
    chk("t3_max_row", res_max_row, 17);
    run_op(21, 21, 3, 3, 777, 1, 1, 0, 0, 0);
    chk("t4_max_row", res_max_row, 18);
    chk("t4_max_col", res_max_col, 18);

    // GRANT withheld for 5 cycles mid-beat.
    run_op(24, 20, 3, 2, 50, 0, 0, 0, 40, 0);
    chk("t5_stalls", res_stalls, 5);

    // Reset during the write phase of beat 3, then restart from base 0.
    run_op(32, 32, 5, 2, 300, 1, 0, 0, 0, 3);
    @(negedge clk);
    chk_idle_outputs("post_abort");
    rst = 1'b0;
    PRE_TAKE_VLD = 1'b0;
    @(negedge clk);
    run_op(20, 18, 2, 2, 0, 1, 1, 0, 0, 0);
    chk("restart_first_addr", res_first_addr, 0);

    // ReLU behaviour on 8001 / 0303 lanes.
    run_op(20, 20, 5, 1, 0, 0, 0, 2, 0, 0);
    chk("relu_0303", res_cnt_0303, 128);
`ifdef CCM_WB_RELU_EN
    chk("relu_8001", res_cnt_8001, 0);
`else
    chk("relu_8001", res_cnt_8001, 128);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
